// File: rtl/fir_decimator_if.sv
// Purpose: bundles the sample input, the result FIFO output and the overflow flag of fir_decimator.
// Latency: no logic here; it only carries signals.
// Backpressure: out_ready stalls the result FIFO; the input side has no backpressure.
// Ports (modport slave = decimator side):
//   in_valid/in_data    upstream filter sample, one per cycle at most
//   out_valid/out_data  FIFO head, first-word fall-through; out_ready pops it
//   overflow            sticky flag: a kept result was dropped on a full FIFO
interface fir_decimator_if #(
    parameter int IN_WIDTH  = 12,
    parameter int OUT_WIDTH = 8
);
    logic                        in_valid;
    logic signed [IN_WIDTH-1:0]  in_data;
    logic signed [OUT_WIDTH-1:0] out_data;
    logic                        out_valid;
    logic                        out_ready;
    logic                        overflow;

    // Drives samples in and consumes results (filter + downstream consumer)
    modport master (
        output in_valid, in_data, out_ready,
        input  out_data, out_valid, overflow
    );

    // The decimator itself
    modport slave (
        input  in_valid, in_data, out_ready,
        output out_data, out_valid, overflow
    );
endinterface

// File: rtl/fir_decimator.sv
// Purpose: decimate filter samples by DECIM, round (half toward +inf) and saturate to OUT_WIDTH, buffer in a FIFO.
// Latency: 2 cycles from a kept in_data to out_data on an empty FIFO.
// Backpressure: out_ready pops the FIFO; a kept result arriving at a full FIFO with no pop is dropped and overflow sticks.
// Ports: clk (rising edge), resetn (synchronous, active low), bus (fir_decimator_if.slave).
// Build option: define FIR_DECIM_AVG_EN to output the average of each DECIM-sample group
// instead of its last sample (DECIM must then be a power of 2).
module fir_decimator #(
    parameter int IN_WIDTH   = 12,
    parameter int OUT_WIDTH  = 8,
    parameter int DECIM      = 2,
    parameter int SHIFT      = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           resetn,
    fir_decimator_if.slave bus
);
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int XW = IN_WIDTH + 1;

    // Rounding constant is half an output LSB; (1<<SHIFT)>>1 yields 0 when SHIFT is 0
    localparam logic signed [XW-1:0] RND  = XW'((1 << SHIFT) >> 1);
    localparam logic signed [XW-1:0] MAXV = XW'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [XW-1:0] MINV = ~MAXV;

    // ------------------------------------------------------------------
    // Phase counter: advances only on valid input cycles
    // ------------------------------------------------------------------
    logic [PW-1:0] phase_q, phase_d;
    logic          last_phase;
    logic          keep;

    assign last_phase = (phase_q == PW'(DECIM - 1));
    assign keep       = bus.in_valid && last_phase;

    always_comb begin
        phase_d = phase_q;
        if (bus.in_valid) begin
            phase_d = last_phase ? '0 : phase_q + PW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Sample selection: last sample of the group, or the group average
    // ------------------------------------------------------------------
    logic signed [IN_WIDTH-1:0] sel_sample;

`ifdef FIR_DECIM_AVG_EN
    localparam int LD = $clog2(DECIM);
    localparam int SW = IN_WIDTH + LD;

    if ((1 << LD) != DECIM) begin : g_bad_decim
        $error("fir_decimator: DECIM must be a power of 2 when averaging");
    end

    logic signed [SW-1:0] acc_q, acc_d, acc_base;

    always_comb begin
        // The first sample of a group starts a fresh sum
        acc_base = (phase_q == '0) ? '0 : acc_q;
        acc_d    = acc_base + SW'(bus.in_data);
    end

    // The group mean always fits back into IN_WIDTH, so truncation is exact
    assign sel_sample = IN_WIDTH'(acc_d >>> LD);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            acc_q <= '0;
        end else if (bus.in_valid) begin
            acc_q <= acc_d;
        end
    end
`else
    assign sel_sample = bus.in_data;
`endif

    // ------------------------------------------------------------------
    // Round and saturate; one extra bit absorbs the rounding carry
    // ------------------------------------------------------------------
    logic signed [XW-1:0]        shifted;
    logic signed [OUT_WIDTH-1:0] sat_val;

    always_comb begin
        shifted = (XW'(sel_sample) + RND) >>> SHIFT;
        if (shifted > MAXV) begin
            sat_val = MAXV[OUT_WIDTH-1:0];
        end else if (shifted < MINV) begin
            sat_val = MINV[OUT_WIDTH-1:0];
        end else begin
            sat_val = shifted[OUT_WIDTH-1:0];
        end
    end

    logic signed [OUT_WIDTH-1:0] res_q;
    logic                        res_vld_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            phase_q   <= '0;
            res_vld_q <= 1'b0;
            res_q     <= '0;
        end else begin
            phase_q   <= phase_d;
            res_vld_q <= keep;
            if (keep) begin
                res_q <= sat_val;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    logic signed [OUT_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]               rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic                        ovf_q, ovf_d;
    logic signed [OUT_WIDTH-1:0] last_q, last_d;
    logic                        empty, full, pop, wr_en;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(FIFO_DEPTH));
    assign pop   = !empty && bus.out_ready;
    // A pop in the same cycle frees the slot a full FIFO needs
    assign wr_en = res_vld_q && (!full || pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        last_d   = last_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            // Remember the popped word so out_data holds it once empty
            last_d   = mem_q[rd_ptr_q];
        end
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (res_vld_q && !wr_en) begin
            ovf_d = 1'b1;
        end
        case ({wr_en, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            last_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            last_q   <= last_d;
        end
    end

    // Storage needs no reset: the count decides what is visible
    always_ff @(posedge clk) begin
        if (resetn && wr_en) begin
            mem_q[wr_ptr_q] <= res_q;
        end
    end

    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? last_q : mem_q[rd_ptr_q];
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_fir_decimator.sv
// Purpose: self-checking bench for fir_decimator against a queue-based reference model.
// Latency: model predicts outputs one cycle at a time from the behavioural rules.
// Backpressure: out_ready driven by directed patterns and random bursts.
module tb_fir_decimator;
    localparam int IN_WIDTH   = 12;
    localparam int OUT_WIDTH  = 8;
    localparam int DECIM      = 2;
    localparam int SHIFT      = 2;
    localparam int FIFO_DEPTH = 4;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    fir_decimator_if #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) bus ();

    fir_decimator #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .DECIM     (DECIM),
        .SHIFT     (SHIFT),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_phase  = 0;
    int m_acc    = 0;
    int m_s1_val = 0;
    bit m_s1_vld = 1'b0;
    int m_last   = 0;
    bit m_ovf    = 1'b0;
    int m_q[$];
    int dut_log[$];

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int floor_div(input int a, input int b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    function automatic int round_sat(input int x);
        int r;
        int lim;
        r   = floor_div(x + (1 << SHIFT) / 2, 1 << SHIFT);
        lim = 1 << (OUT_WIDTH - 1);
        if (r > lim - 1) r = lim - 1;
        if (r < -lim) r = -lim;
        return r;
    endfunction

    // Applies the rules for one rising edge, given the inputs of that cycle
    task automatic model_step(input bit v, input int d, input bit rdy);
        if (!resetn) begin
            m_phase  = 0;
            m_acc    = 0;
            m_s1_vld = 1'b0;
            m_q.delete();
            m_last   = 0;
            m_ovf    = 1'b0;
        end else begin
            if (rdy && m_q.size() > 0) m_last = m_q.pop_front();
            if (m_s1_vld) begin
                if (m_q.size() < FIFO_DEPTH) m_q.push_back(m_s1_val);
                else m_ovf = 1'b1;
            end
            m_s1_vld = 1'b0;
            if (v) begin
                if (m_phase == 0) m_acc = 0;
                m_acc += d;
                if (m_phase == DECIM - 1) begin
                    m_s1_vld = 1'b1;
`ifdef FIR_DECIM_AVG_EN
                    m_s1_val = round_sat(floor_div(m_acc, DECIM));
`else
                    m_s1_val = round_sat(d);
`endif
                end
                m_phase = (m_phase + 1) % DECIM;
            end
        end
    endtask

    // Called just after a falling edge: drive, step the model at the rising edge, compare at the next falling edge
    task automatic cycle(input bit v, input int d, input bit rdy);
        bus.in_valid  = v;
        bus.in_data   = IN_WIDTH'(d);
        bus.out_ready = rdy;
        #1;
        if (bus.out_valid && rdy) dut_log.push_back(int'(bus.out_data));
        @(posedge clk);
        model_step(v, d, rdy);
        @(negedge clk);
        check("out_valid", bus.out_valid, m_q.size() > 0);
        check("out_data", bus.out_data, (m_q.size() > 0) ? m_q[0] : m_last);
        check("overflow", bus.overflow, m_ovf);
    endtask

    function automatic int rnd_sample();
        return int'($urandom_range(0, (1 << IN_WIDTH) - 1)) - (1 << (IN_WIDTH - 1));
    endfunction

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, rnd_sample(), rdy);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b1, rnd_sample(), 1'b1);
        resetn = 1'b1;
        dut_log.delete();
    endtask

    task automatic expect_log(input string tag, input int exp[$]);
        check({tag, "_count"}, dut_log.size(), exp.size());
        foreach (exp[i]) begin
            if (i < dut_log.size()) check(tag, dut_log[i], exp[i]);
        end
        dut_log.delete();
    endtask

    int e[$];
    bit rdy_mode;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);

        // Reset held with valid input: outputs stay idle
        do_reset();

        // Decimate and round
        cycle(1'b1, 4, 1'b1);  cycle(1'b1, 8, 1'b1);
        cycle(1'b1, 6, 1'b1);  cycle(1'b1, -6, 1'b1);
        cycle(1'b1, -1, 1'b1); cycle(1'b1, -6, 1'b1);
        idle(4, 1'b1);
`ifndef FIR_DECIM_AVG_EN
        e = '{2, -1, -1};
        expect_log("decim", e);
`endif

        // Saturation
        do_reset();
        cycle(1'b1, 0, 1'b1); cycle(1'b1, 2047, 1'b1);
        cycle(1'b1, 0, 1'b1); cycle(1'b1, -2048, 1'b1);
        cycle(1'b1, 0, 1'b1); cycle(1'b1, 510, 1'b1);
        cycle(1'b1, 0, 1'b1); cycle(1'b1, -514, 1'b1);
        idle(4, 1'b1);
`ifndef FIR_DECIM_AVG_EN
        e = '{127, -128, 127, -128};
        expect_log("sat", e);
`endif

        // Idle gaps do not advance the phase
        do_reset();
        cycle(1'b1, 10, 1'b1);
        cycle(1'b0, rnd_sample(), 1'b1);
        cycle(1'b0, rnd_sample(), 1'b1);
        cycle(1'b1, 20, 1'b1);
        cycle(1'b0, rnd_sample(), 1'b1);
        cycle(1'b1, 30, 1'b1);
        cycle(1'b1, 40, 1'b1);
        idle(4, 1'b1);
`ifndef FIR_DECIM_AVG_EN
        e = '{5, 10};
        expect_log("gaps", e);
`endif

        // Overflow: fifth kept result hits a full FIFO with no pop
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 0, 1'b0);
            cycle(1'b1, 20 + 4 * i, 1'b0);
        end
        idle(3, 1'b0);
`ifndef FIR_DECIM_AVG_EN
        check("ovf_head", bus.out_data, 5);
        check("ovf_set", bus.overflow, 1);
`endif
        idle(6, 1'b1);
`ifndef FIR_DECIM_AVG_EN
        e = '{5, 6, 7, 8};
        expect_log("ovf_drain", e);
        check("ovf_sticky", bus.overflow, 1);
        check("ovf_empty", bus.out_valid, 0);
`endif

        // Same burst, but a pop coincides with the fifth push
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 0, 1'b0);
            cycle(1'b1, 20 + 4 * i, 1'b0);
        end
        cycle(1'b0, 0, 1'b1);
        idle(2, 1'b0);
`ifndef FIR_DECIM_AVG_EN
        check("nodrop_ovf", bus.overflow, 0);
`endif
        idle(6, 1'b1);
`ifndef FIR_DECIM_AVG_EN
        e = '{5, 6, 7, 8, 9};
        expect_log("nodrop", e);
`endif

`ifdef FIR_DECIM_AVG_EN
        // Group averaging
        do_reset();
        cycle(1'b1, 8, 1'b1);  cycle(1'b1, 16, 1'b1);
        cycle(1'b1, -3, 1'b1); cycle(1'b1, -4, 1'b1);
        idle(4, 1'b1);
        e = '{3, -1};
        expect_log("avg", e);
`endif

        // Randomized traffic with bursts of backpressure and occasional resets
        do_reset();
        rdy_mode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) rdy_mode = ($urandom_range(0, 2) != 0);
            resetn = ($urandom_range(0, 249) != 0);
            cycle($urandom_range(0, 3) != 0, rnd_sample(),
                  rdy_mode ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0));
        end
        resetn = 1'b1;
        idle(8, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fir_decimator.md
Name: fir_decimator

Overview:
- Downstream stage of the FIR filter: consumes the filter's widened signed output samples, decimates by a fixed factor, rounds and saturates back to the narrow sample width, and buffers results in a small FIFO with a valid/ready output interface.
- Sits between the filter and any consumer that cannot accept a result every cycle.

Parameters:
- IN_WIDTH, 12, width of signed input sample (filter output width).
- OUT_WIDTH, 8, width of signed output sample.
- DECIM, 2, decimation factor (>=1); one of every DECIM accepted samples is kept.
- SHIFT, 2, arithmetic right shift applied before saturation (0..IN_WIDTH-1).
- FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2).

Ports:
- clk  input  1  clock; all logic on rising edge.
- resetn  input  1  synchronous, active-low reset.
- in_valid  input  1  in_data carries a sample this cycle; no backpressure upstream.
- in_data  input  IN_WIDTH  signed filter sample.
- out_data  output  OUT_WIDTH  signed FIFO head (first-word fall-through).
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts out_data when out_valid & out_ready.
- overflow  output  1  sticky: a kept sample was dropped because the FIFO was full.

Behaviour:
- Reset (resetn low at a rising edge): phase counter=0, pipeline valid=0, FIFO empty (pointers=0, count=0), out_valid=0, out_data=0, overflow=0. Reset mid-operation discards all in-flight and buffered samples; the next accepted sample is phase 0.
- Phase counter: counts 0..DECIM-1 and advances only on cycles with in_valid=1; wraps DECIM-1 -> 0. A sample is kept when in_valid=1 and phase==DECIM-1. DECIM=1 keeps every sample.
- Arithmetic, on the kept sample, at IN_WIDTH+1 bits: r = (in_data + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT (round half toward +inf). Saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- Pipeline: the rounded/saturated result and a valid bit are registered at the edge ending the kept cycle t; FIFO write is at the edge ending t+1; out_valid is high in cycle t+2 when the FIFO was empty. Latency from in_data to out_data is 2 cycles.
- FIFO pop: occurs on out_valid & out_ready. out_data holds stable while out_valid=1 and out_ready=0.
- FIFO push when full: if a pop occurs in the same cycle, the push is accepted (count unchanged). Otherwise the sample is dropped, FIFO contents are unchanged, and overflow is set to 1 and held until reset.
- Push and pop in the same cycle when not full: both take effect; count unchanged.
- Empty FIFO: out_valid=0; out_ready is ignored; out_data holds its last value (0 after reset).
- Drops do not affect the phase counter.

Optional Feature:
- Macro FIR_DECIM_AVG_EN.
- Defined: keep-one selection is replaced by group averaging. An accumulator of IN_WIDTH+log2(DECIM) bits sums the DECIM samples of each group, clears at group start, and is divided by arithmetic right shift of log2(DECIM). The result then goes through the same rounding/saturation and timing; it is registered at the edge ending the last sample of the group. DECIM must be a power of 2; elaboration fails otherwise. Reset clears the accumulator.
- Undefined: last-sample-of-group selection; no accumulator logic is present.

Test Plan:
- Reset: hold resetn=0 for 3 cycles with in_valid=1 -> out_valid=0, overflow=0, out_data=0 throughout; first sample after release is phase 0.
- Decimate/round (defaults, out_ready=1): in_valid=1 continuously, in_data=4,8,6,-6,-1,-6 -> outputs 2, -1, -1 (samples kept: 8, -6, -6); each output appears 2 cycles after its kept sample.
- Saturation: kept samples 2047 and -2048 -> out_data 127 then -128; kept 510 -> 127; kept -514 -> -128.
- Gaps: in_valid pattern 1,0,0,1,0,1,1 with data 10,x,x,20,x,30,40 -> outputs 5 and 10 (from 20 and 40); phase does not advance on idle cycles.
- Backpressure/overflow: out_ready=0, 5 kept samples (20,24,28,32,36) -> 4 entries held (out_data=5), 5th dropped, overflow=1; then out_ready=1 -> pops 5,6,7,8 in order, out_valid falls, overflow stays 1. Repeat with out_ready=1 during the 5th push cycle -> no drop, overflow stays 0.
- FIR_DECIM_AVG_EN, DECIM=2: pairs (8,16),(-3,-4) -> averages 12 and -4 -> outputs 3 and -1.
